dmem_store_buffer: RTL and testbench
====================================

Name: dmem_store_buffer

Overview:
Sits directly downstream of the core's data-memory port, between the core and the shared data memory. Posted stores are queued in a small FIFO and drained to memory through a valid/ready write port. Loads read memory with 1-cycle latency, and the bytes are merged with store-to-load forwarding from the queue. The block asserts a stall when the queue is full so the pipeline holds the store.

Parameters:
DATA_WIDTH, 32, data and address width in bits; a word is DATA_WIDTH/8 bytes.
DEPTH, 4, number of store queue entries; power of two, at least 2.

Ports:
clk  in  1  clock
arst_n  in  1  asynchronous active-low reset
core_addr  in  DATA_WIDTH  byte address from core; the low log2(DATA_WIDTH/8) bits are ignored (word address)
core_wdata  in  DATA_WIDTH  store data, already lane-aligned
core_we  in  1  store request this cycle
core_re  in  1  load request this cycle
core_mask  in  DATA_WIDTH/8  byte-enable mask for the store
core_rdata  out  DATA_WIDTH  load data, valid the cycle after core_re
core_stall  out  1  queue full; the store was not accepted and the core must hold it
mem_raddr  out  DATA_WIDTH  read address to memory (combinational = core_addr)
mem_rdata  in  DATA_WIDTH  memory read data, 1 cycle after mem_raddr
mem_wvalid  out  1  head entry valid for write
mem_wready  in  1  memory accepts the write
mem_waddr  out  DATA_WIDTH  head entry word address
mem_wdata  out  DATA_WIDTH  head entry data
mem_wmask  out  DATA_WIDTH/8  head entry mask
count  out  $clog2(DEPTH)+1  occupancy

Behaviour:
- Reset (async, arst_n low): all queue valid bits 0, pointers 0, count 0, core_rdata 0, mem_wvalid 0, core_stall 0. mem_waddr, mem_wdata and mem_wmask are 0 while the queue is empty. Reset applied mid-drain discards all queued stores.
- Queue storage: circular FIFO with read pointer, write pointer and count. Each entry holds {word addr, data, mask}.
- Enqueue: occurs when core_we=1 and count<DEPTH.
  - The entry is written at the write pointer; the pointer wraps modulo DEPTH.
  - A store with core_mask=0 is dropped (no enqueue).
- core_stall = core_we & (count==DEPTH). It is combinational and is asserted even when the same cycle drains an entry (no same-cycle full bypass). The stalled store is re-presented by the core and accepted in the first cycle count<DEPTH.
- Drain:
  - mem_wvalid = (count!=0); mem_w* show the head entry.
  - On mem_wvalid & mem_wready, the read pointer advances (wrapping).
  - mem_w* must stay stable while mem_wvalid=1 and mem_wready=0.
- Simultaneous enqueue and dequeue: count is unchanged, and both pointers advance. With count==1, the new entry becomes head next cycle.
- core_we and core_re both high: the store is taken and the load is ignored (core_rdata next cycle = 0).
- Load path:
  - At the load cycle t, a forward snapshot is taken over all valid entries whose word address equals core_addr's word address.
  - For each byte lane, the youngest matching entry with that mask bit set supplies the byte.
  - The entry draining in cycle t is still included.
  - The snapshot data and hit mask are registered.
  - At t+1: core_rdata byte i = hit[i] ? fwd[i] : mem_rdata byte i.
  - core_rdata is registered/merged so that it is valid exactly at t+1. It is 0 in any cycle not following a load.
- Latency: load data 1 cycle. A store is visible to forwarding from the cycle after enqueue. There is no same-cycle store-to-load bypass, because a store and a load cannot share a cycle.
- Ordering: stores reach memory in program order and are never merged or reordered.

Test Plan:
- Reset released, sw 0x100←0xDEADBEEF mask 0xF, mem_wready=1 -> next cycle mem_wvalid=1, mem_waddr=0x100, mem_wdata=0xDEADBEEF; the cycle after, count=0 and mem_wvalid=0.
- mem_wready=0, 5 stores 0x0,0x4,0x8,0xC,0x10 with DEPTH=4 -> count=4; core_stall=1 on the 5th; raising mem_wready for 1 cycle leaves the 5th accepted the next cycle, count=4; drain order 0x0,0x4,0x8,0xC,0x10.
- mem_wready=0, sb 0x200 data 0x000000AA mask 0x1, then sh 0x200 data 0x0000BB00 mask 0x2 (younger), then load 0x200 with mem_rdata=0x11223344 -> core_rdata=0x1122BBAA.
- Wrap-around: 10 stores at full drain rate with a load after each -> pointers wrap, each load returns the forwarded value or memory data correctly, count never exceeds DEPTH.
- core_we=core_re=1 at 0x300 -> store enqueued; core_rdata=0 next cycle.
- arst_n pulsed low with count=3 and mem_wvalid=1 -> immediately mem_wvalid=0, count=0, core_stall=0; a subsequent load from 0x0 returns raw mem_rdata.

Source files
------------

// File: rtl/dmem_store_buffer.sv
// Posted-store FIFO between the core data port and shared data memory.
// Drains stores in order and forwards queued bytes into 1-cycle loads.
module dmem_store_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                        clk,
  input  logic                        arst_n,
  input  logic [DATA_WIDTH-1:0]       core_addr,
  input  logic [DATA_WIDTH-1:0]       core_wdata,
  input  logic                        core_we,
  input  logic                        core_re,
  input  logic [DATA_WIDTH/8-1:0]     core_mask,
  output logic [DATA_WIDTH-1:0]       core_rdata,
  output logic                        core_stall,
  output logic [DATA_WIDTH-1:0]       mem_raddr,
  input  logic [DATA_WIDTH-1:0]       mem_rdata,
  output logic                        mem_wvalid,
  input  logic                        mem_wready,
  output logic [DATA_WIDTH-1:0]       mem_waddr,
  output logic [DATA_WIDTH-1:0]       mem_wdata,
  output logic [DATA_WIDTH/8-1:0]     mem_wmask,
  output logic [$clog2(DEPTH):0]      count
);

  localparam int NB = DATA_WIDTH / 8;
  localparam int AW = $clog2(DEPTH);
  localparam int LB = $clog2(NB);
  localparam int CW = AW + 1;

  typedef logic [AW-1:0] ptr_t;

  logic [DATA_WIDTH-1:0] r_addr [DEPTH];
  logic [DATA_WIDTH-1:0] r_data [DEPTH];
  logic [NB-1:0]         r_mask [DEPTH];
  logic [DEPTH-1:0]      r_vld;
  ptr_t                  r_rptr;
  ptr_t                  r_wptr;
  logic [CW-1:0]         r_count;
  logic                  r_ld;
  logic [NB-1:0]         r_hit;
  logic [DATA_WIDTH-1:0] r_fwd;

  logic [DATA_WIDTH-1:0] w_waddr;
  logic                  w_full;
  logic                  w_enq;
  logic                  w_deq;
  logic                  w_ld;
  logic [NB-1:0]         w_hit;
  logic [DATA_WIDTH-1:0] w_fwd;
  ptr_t                  w_idx;
  logic                  w_unused;

  assign w_unused = ^core_addr[LB-1:0];
  assign w_waddr  = {core_addr[DATA_WIDTH-1:LB], {LB{1'b0}}};
  assign w_full   = (r_count == CW'(DEPTH));
  assign w_enq    = core_we & ~w_full & (|core_mask);
  assign w_deq    = mem_wvalid & mem_wready;
  assign w_ld     = core_re & ~core_we;

  assign core_stall = core_we & w_full;
  assign mem_raddr  = core_addr;
  assign mem_wvalid = (r_count != '0);
  assign mem_waddr  = mem_wvalid ? r_addr[r_rptr] : '0;
  assign mem_wdata  = mem_wvalid ? r_data[r_rptr] : '0;
  assign mem_wmask  = mem_wvalid ? r_mask[r_rptr] : '0;
  assign count      = r_count;

  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_addr[r_wptr] <= w_waddr;
      r_data[r_wptr] <= core_wdata;
      r_mask[r_wptr] <= core_mask;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_vld   <= '0;
      r_rptr  <= '0;
      r_wptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_deq) begin
        r_vld[r_rptr] <= 1'b0;
        r_rptr        <= r_rptr + 1'b1;
      end
      if (w_enq) begin
        r_vld[r_wptr] <= 1'b1;
        r_wptr        <= r_wptr + 1'b1;
      end
      r_count <= r_count + CW'(w_enq) - CW'(w_deq);
    end
  end

  // Walk oldest to youngest so younger stores overwrite older lanes.
  always_comb begin
    w_hit = '0;
    w_fwd = '0;
    w_idx = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_idx = r_rptr + ptr_t'(k);
      if (r_vld[w_idx] && (r_addr[w_idx] == w_waddr)) begin
        for (int b = 0; b < NB; b++) begin
          if (r_mask[w_idx][b]) begin
            w_hit[b]       = 1'b1;
            w_fwd[8*b +: 8] = r_data[w_idx][8*b +: 8];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_ld  <= 1'b0;
      r_hit <= '0;
      r_fwd <= '0;
    end else begin
      r_ld  <= w_ld;
      r_hit <= w_ld ? w_hit : '0;
      r_fwd <= w_ld ? w_fwd : '0;
    end
  end

  // Memory data lands the cycle after the load; merge it with the snapshot.
  always_comb begin
    core_rdata = '0;
    if (r_ld) begin
      for (int b = 0; b < NB; b++) begin
        core_rdata[8*b +: 8] = r_hit[b] ? r_fwd[8*b +: 8]
                                        : mem_rdata[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_store_buffer.sv
// Scoreboard bench for dmem_store_buffer: drain and load-data monitors
// compare against queues filled by the directed stimulus.
module tb_dmem_store_buffer;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  mask;
  } wr_t;

  logic        clk = 1'b0;
  logic        arst_n;
  logic [31:0] core_addr, core_wdata, core_rdata;
  logic        core_we, core_re, core_stall;
  logic [3:0]  core_mask;
  logic [31:0] mem_raddr, mem_rdata;
  logic        mem_wvalid, mem_wready;
  logic [31:0] mem_waddr, mem_wdata;
  logic [3:0]  mem_wmask;
  logic [2:0]  count;

  int n_chk  = 0;
  int n_fail = 0;

  wr_t         wq[$];
  logic [31:0] rq[$];
  wr_t         exp_w;
  logic [31:0] exp_r;
  logic        tb_rvalid;

  dmem_store_buffer #(.DATA_WIDTH(32), .DEPTH(4)) dut (
    .clk(clk), .arst_n(arst_n),
    .core_addr(core_addr), .core_wdata(core_wdata),
    .core_we(core_we), .core_re(core_re),
    .core_mask(core_mask), .core_rdata(core_rdata),
    .core_stall(core_stall), .mem_raddr(mem_raddr),
    .mem_rdata(mem_rdata), .mem_wvalid(mem_wvalid),
    .mem_wready(mem_wready), .mem_waddr(mem_waddr),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .count(count)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge arst_n)
    if (!arst_n) tb_rvalid <= 1'b0;
    else         tb_rvalid <= core_re;

  always @(negedge clk) begin
    if (arst_n && mem_wvalid && mem_wready) begin
      n_chk++;
      if (wq.size() == 0) begin
        n_fail++;
        $display("FAIL drain_unexpected got a=%h d=%h m=%h need none",
                 mem_waddr, mem_wdata, mem_wmask);
      end else begin
        exp_w = wq.pop_front();
        if ({mem_waddr, mem_wdata, mem_wmask} !==
            {exp_w.addr, exp_w.data, exp_w.mask}) begin
          n_fail++;
          $display("FAIL drain got a=%h d=%h m=%h need a=%h d=%h m=%h",
                   mem_waddr, mem_wdata, mem_wmask,
                   exp_w.addr, exp_w.data, exp_w.mask);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (arst_n && tb_rvalid) begin
      n_chk++;
      if (rq.size() == 0) begin
        n_fail++;
        $display("FAIL rdata_unexpected got %h", core_rdata);
      end else begin
        exp_r = rq.pop_front();
        if (core_rdata !== exp_r) begin
          n_fail++;
          $display("FAIL rdata got %h need %h", core_rdata, exp_r);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got %h need %h", nm, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] m);
    core_we    = 1'b1;
    core_addr  = a;
    core_wdata = d;
    core_mask  = m;
    if (m != 4'h0) wq.push_back('{addr: a, data: d, mask: m});
    step();
    core_we = 1'b0;
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] memv,
                      input logic [31:0] exp);
    core_re   = 1'b1;
    core_addr = a;
    rq.push_back(exp);
    step();
    core_re   = 1'b0;
    mem_rdata = memv;
  endtask

  task automatic drain(input string nm);
    mem_wready = 1'b1;
    for (int i = 0; i < 20 && count != 3'd0; i++) step();
    chk(nm, 32'(count), 32'd0);
  endtask

  logic [31:0] d;
  logic [3:0]  m;

  initial begin
    arst_n     = 1'b0;
    core_addr  = '0;
    core_wdata = '0;
    core_we    = 1'b0;
    core_re    = 1'b0;
    core_mask  = '0;
    mem_rdata  = '0;
    mem_wready = 1'b0;
    #3;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_wvalid", 32'(mem_wvalid), 32'd0);
    chk("rst_stall", 32'(core_stall), 32'd0);
    chk("rst_rdata", core_rdata, 32'd0);
    chk("rst_waddr", mem_waddr, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    step();
    step();
    arst_n = 1'b1;

    mem_wready = 1'b1;
    store(32'h100, 32'hDEADBEEF, 4'hF);
    chk("sw_wvalid", 32'(mem_wvalid), 32'd1);
    chk("sw_waddr", mem_waddr, 32'h100);
    chk("sw_wdata", mem_wdata, 32'hDEADBEEF);
    step();
    chk("sw_count0", 32'(count), 32'd0);
    chk("sw_wvalid0", 32'(mem_wvalid), 32'd0);

    mem_wready = 1'b0;
    for (int i = 0; i < 4; i++)
      store(32'(4 * i), 32'h1000 + 32'(i), 4'hF);
    chk("full_count", 32'(count), 32'd4);
    core_we    = 1'b1;
    core_addr  = 32'h10;
    core_wdata = 32'h1004;
    core_mask  = 4'hF;
    wq.push_back('{addr: 32'h10, data: 32'h1004, mask: 4'hF});
    #1;
    chk("full_stall", 32'(core_stall), 32'd1);
    mem_wready = 1'b1;
    step();
    mem_wready = 1'b0;
    chk("pop_count", 32'(count), 32'd3);
    chk("pop_stall", 32'(core_stall), 32'd0);
    step();
    core_we = 1'b0;
    chk("refill_count", 32'(count), 32'd4);
    drain("full_drain");

    mem_wready = 1'b0;
    store(32'h200, 32'h000000AA, 4'h1);
    store(32'h200, 32'h0000BB00, 4'h2);
    load(32'h200, 32'h11223344, 32'h1122BBAA);
    step();
    drain("fwd_drain");

    mem_wready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      d = 32'hA0B0C000 + 32'(i);
      m = (i % 2 == 1) ? 4'h3 : 4'hF;
      store(32'h500 + 32'(4 * i), d, m);
      load(32'h500 + 32'(4 * i), 32'h55555555,
           (m == 4'h3) ? {16'h5555, d[15:0]} : d);
      chk("wrap_count_le", 32'(count <= 3'd4), 32'd1);
    end
    step();
    chk("wrap_empty", 32'(count), 32'd0);

    mem_wready = 1'b0;
    core_we    = 1'b1;
    core_re    = 1'b1;
    core_addr  = 32'h300;
    core_wdata = 32'h3333;
    core_mask  = 4'hF;
    wq.push_back('{addr: 32'h300, data: 32'h3333, mask: 4'hF});
    rq.push_back(32'h0);
    step();
    core_we   = 1'b0;
    core_re   = 1'b0;
    mem_rdata = 32'hFFFFFFFF;
    chk("we_re_count", 32'(count), 32'd1);
    step();
    drain("we_re_drain");

    mem_wready = 1'b0;
    store(32'h40, 32'h1, 4'hF);
    store(32'h44, 32'h2, 4'hF);
    store(32'h48, 32'h3, 4'hF);
    chk("pre_rst_count", 32'(count), 32'd3);
    chk("pre_rst_wvalid", 32'(mem_wvalid), 32'd1);
    arst_n = 1'b0;
    #1;
    wq.delete();
    chk("mid_rst_count", 32'(count), 32'd0);
    chk("mid_rst_wvalid", 32'(mem_wvalid), 32'd0);
    chk("mid_rst_stall", 32'(core_stall), 32'd0);
    step();
    arst_n     = 1'b1;
    mem_wready = 1'b1;
    load(32'h0, 32'hCAFEF00D, 32'hCAFEF00D);
    chk("post_rst_wvalid", 32'(mem_wvalid), 32'd0);
    step();
    step();

    chk("wq_empty", 32'(wq.size()), 32'd0);
    chk("rq_empty", 32'(rq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
